// File: rtl/lc3_pipe_controller.sv
// Stall/enable sequencer for the 5-stage LC-3 pipe: pipeline fill, instruction wait,
// branch bubbles, data-memory freeze and RAW handling. Optional macro: LC3_BYPASS_EN.
module lc3_pipe_controller #(
  parameter int BR_BUBBLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  NZP,
  output logic        enable_fetch,
  output logic        enable_updatePC,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic [1:0]  mem_state,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2
);

  typedef enum logic [1:0] {RUN, CTRL, MEM_IND, MEM_RW} state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;

  state_t      state_reg;
  logic [1:0]  cnt_reg;
  logic [2:0]  fill_sr_reg;
  logic        is_store_reg;
  logic [1:0]  mem_state_reg;

  logic [3:0]  op_d;
  logic [3:0]  op_x;
  logic        hazard_1;
  logic        hazard_2;
  logic        raw_stall;
  logic        fetch_req;
  logic        instr_wait;
  logic        advance;
  logic        unused_bits;

  assign op_d = IR[15:12];
  assign op_x = IR_Exec[15:12];
  assign unused_bits = ^{IR[11:9], IR[4:3], IR_Exec[8:0]};

  // RAW match: execute holds an ALU producer whose DR is a source of the decode instruction
  assign hazard_1 = (op_x inside {OP_ADD, OP_AND, OP_NOT}) && (IR_Exec[11:9] == IR[8:6]) &&
                    (op_d inside {OP_ADD, OP_AND, OP_NOT, OP_LDR, OP_STR, OP_JMP});
  assign hazard_2 = (op_x inside {OP_ADD, OP_AND, OP_NOT}) && (op_d inside {OP_ADD, OP_AND}) &&
                    !IR[5] && (IR_Exec[11:9] == IR[2:0]);

`ifdef LC3_BYPASS_EN
  assign bypass_alu_1 = hazard_1;
  assign bypass_alu_2 = hazard_2;
  assign raw_stall    = 1'b0;
`else
  logic stall_done_reg;

  assign bypass_alu_1 = 1'b0;
  assign bypass_alu_2 = 1'b0;
  // A held producer/consumer pair stalls once, then is released on the following cycle
  assign raw_stall    = (hazard_1 || hazard_2) && (state_reg == RUN) && !stall_done_reg;

  always_ff @(posedge clock) begin
    if (reset) stall_done_reg <= 1'b0;
    else       stall_done_reg <= raw_stall;
  end
`endif

  always_comb begin
    fetch_req = 1'b0;
    case (state_reg)
      RUN:     fetch_req = !raw_stall;
      CTRL:    fetch_req = (cnt_reg == 2'd0);
      default: fetch_req = 1'b0;
    endcase
    instr_wait       = fetch_req && !complete_instr;
    advance          = ((state_reg == RUN) || (state_reg == CTRL)) && !instr_wait;
    enable_fetch     = fetch_req && !instr_wait;
    enable_updatePC  = fetch_req && !instr_wait;
    enable_decode    = (state_reg == RUN) && advance && fill_sr_reg[0] && !raw_stall;
    enable_execute   = advance && fill_sr_reg[1];
    enable_writeback = advance && fill_sr_reg[2];
    br_taken         = (state_reg == CTRL) && (cnt_reg == 2'd0) &&
                       ((op_x == OP_JMP) || ((op_x == OP_BR) && |(IR_Exec[11:9] & NZP)));
  end

  assign mem_state = mem_state_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= RUN;
      cnt_reg       <= 2'd0;
      fill_sr_reg   <= 3'b000;
      is_store_reg  <= 1'b0;
      mem_state_reg <= 2'd3;
    end else begin
      case (state_reg)
        RUN: if (advance) begin
          fill_sr_reg <= {fill_sr_reg[1:0], 1'b1};
          // memory in execute outranks a control instruction leaving decode
          if (op_x == OP_LDI || op_x == OP_STI) begin
            state_reg     <= MEM_IND;
            mem_state_reg <= 2'd2;
            is_store_reg  <= (op_x == OP_STI);
          end else if (op_x inside {OP_LD, OP_LDR, OP_ST, OP_STR}) begin
            state_reg     <= MEM_RW;
            mem_state_reg <= {1'b0, (op_x == OP_ST) || (op_x == OP_STR)};
            is_store_reg  <= (op_x == OP_ST) || (op_x == OP_STR);
          end else if (enable_decode && (op_d == OP_BR || op_d == OP_JMP)) begin
            state_reg <= CTRL;
            cnt_reg   <= 2'(BR_BUBBLES);
          end
        end
        CTRL: if (advance) begin
          fill_sr_reg <= {fill_sr_reg[1:0], 1'b1};
          if (cnt_reg == 2'd0) state_reg <= RUN;
          else                 cnt_reg   <= cnt_reg - 2'd1;
        end
        MEM_IND: if (complete_data) begin
          state_reg     <= MEM_RW;
          mem_state_reg <= {1'b0, is_store_reg};
        end
        default: if (complete_data) begin
          state_reg     <= RUN;
          mem_state_reg <= 2'd3;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Bench for lc3_pipe_controller: directed vector table, then random stimulus against
// a stage-count/bubble-count reference model.
module tb_lc3_pipe_controller;

  localparam int BUB = 2;
`ifdef LC3_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [15:0] NOP  = 16'hD000;
  localparam logic [15:0] BRZ  = 16'h0400;
  localparam logic [15:0] BRN  = 16'h0800;
  localparam logic [15:0] BR0  = 16'h0000;
  localparam logic [15:0] JMP1 = 16'hC040;
  localparam logic [15:0] LDI  = 16'hA000;
  localparam logic [15:0] STR  = 16'h7000;
  localparam logic [15:0] ADD1 = 16'h1260;
  localparam logic [15:0] ADD2 = 16'h1441;

  logic        clock = 1'b0;
  logic        reset, complete_instr, complete_data;
  logic [15:0] IR, IR_Exec;
  logic [2:0]  NZP;
  logic        enable_fetch, enable_updatePC, enable_decode, enable_execute, enable_writeback;
  logic        br_taken, bypass_alu_1, bypass_alu_2;
  logic [1:0]  mem_state;
  logic [9:0]  actual;

  always #5 clock = ~clock;

  lc3_pipe_controller #(.BR_BUBBLES(BUB)) dut (
    .clock(clock), .reset(reset), .complete_instr(complete_instr), .complete_data(complete_data),
    .IR(IR), .IR_Exec(IR_Exec), .NZP(NZP),
    .enable_fetch(enable_fetch), .enable_updatePC(enable_updatePC), .enable_decode(enable_decode),
    .enable_execute(enable_execute), .enable_writeback(enable_writeback), .br_taken(br_taken),
    .mem_state(mem_state), .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2)
  );

  assign actual = {enable_fetch, enable_updatePC, enable_decode, enable_execute, enable_writeback,
                   br_taken, mem_state, bypass_alu_1, bypass_alu_2};

  typedef struct {
    logic        rst, ci, cd;
    logic [15:0] ir, ire;
    logic [2:0]  nzp;
    logic        chk;
    logic [9:0]  exp;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [9:0] pk(input logic f, u, d, e, w, br, input logic [1:0] mem,
                                    input logic b1, b2);
    return {f, u, d, e, w, br, mem, b1, b2};
  endfunction

  function automatic void add(input logic rst, ci, cd, input logic [15:0] ir, ire,
                              input logic [2:0] nzp, input logic chk, input logic [9:0] exp);
    vec_t v;
    v.rst = rst; v.ci = ci; v.cd = cd; v.ir = ir; v.ire = ire; v.nzp = nzp; v.chk = chk; v.exp = exp;
    tbl.push_back(v);
  endfunction

  task automatic compare(input string name, input logic [9:0] want);
    checks++;
    if (actual !== want) begin
      failures++;
      $display("FAIL %s got={f,u,d,e,w,br,mem,b1,b2}=%b want=%b", name, actual, want);
    end
  endtask

  // reference model: count of valid downstream stages, branch-shadow countdown, pending memory phases
  int m_valid, m_shadow, m_mem;
  bit m_store, m_stalled;

  task automatic model_reset();
    m_valid = 0; m_shadow = -1; m_mem = 0; m_store = 0; m_stalled = 0;
  endtask

  initial begin
    logic [9:0] run_all;
    run_all = pk(1,1,1,1,1,0,2'd3,0,0);
    reset = 1'b1; complete_instr = 1'b1; complete_data = 1'b0; IR = NOP; IR_Exec = NOP; NZP = 3'b000;

    // reset and fill
    add(1,1,0, NOP, NOP, 3'b000, 0, '0);
    add(1,1,0, NOP, NOP, 3'b000, 1, pk(1,1,0,0,0,0,2'd3,0,0));
    add(0,1,0, NOP, NOP, 3'b000, 1, pk(1,1,0,0,0,0,2'd3,0,0));
    add(0,1,0, NOP, NOP, 3'b000, 1, pk(1,1,1,0,0,0,2'd3,0,0));
    add(0,1,0, NOP, NOP, 3'b000, 1, pk(1,1,1,1,0,0,2'd3,0,0));
    add(0,1,0, NOP, NOP, 3'b000, 1, run_all);
    // BR z taken
    add(0,1,0, BRZ, NOP, 3'b010, 1, run_all);
    add(0,1,0, NOP, BRZ, 3'b010, 1, pk(0,0,0,1,1,0,2'd3,0,0));
    add(0,1,0, NOP, BRZ, 3'b010, 1, pk(0,0,0,1,1,0,2'd3,0,0));
    add(0,1,0, NOP, BRZ, 3'b010, 1, pk(1,1,0,1,1,1,2'd3,0,0));
    add(0,1,0, NOP, NOP, 3'b010, 1, run_all);
    // BR n not taken
    add(0,1,0, BRN, NOP, 3'b001, 1, run_all);
    add(0,1,0, NOP, BRN, 3'b001, 1, pk(0,0,0,1,1,0,2'd3,0,0));
    add(0,1,0, NOP, BRN, 3'b001, 1, pk(0,0,0,1,1,0,2'd3,0,0));
    add(0,1,0, NOP, BRN, 3'b001, 1, pk(1,1,0,1,1,0,2'd3,0,0));
    add(0,1,0, NOP, NOP, 3'b001, 1, run_all);
    // instruction memory wait
    add(0,0,0, NOP, NOP, 3'b000, 1, pk(0,0,0,0,0,0,2'd3,0,0));
    add(0,1,0, NOP, NOP, 3'b000, 1, run_all);
    // LDI: indirect 3 cycles, direct 2 cycles
    add(0,1,0, NOP, LDI, 3'b000, 1, run_all);
    add(0,1,0, NOP, NOP, 3'b000, 1, pk(0,0,0,0,0,0,2'd2,0,0));
    add(0,1,0, NOP, NOP, 3'b000, 1, pk(0,0,0,0,0,0,2'd2,0,0));
    add(0,1,1, NOP, NOP, 3'b000, 1, pk(0,0,0,0,0,0,2'd2,0,0));
    add(0,1,0, NOP, NOP, 3'b000, 1, pk(0,0,0,0,0,0,2'd0,0,0));
    add(0,1,1, NOP, NOP, 3'b000, 1, pk(0,0,0,0,0,0,2'd0,0,0));
    add(0,1,0, NOP, NOP, 3'b000, 1, run_all);
    // STR interrupted by reset
    add(0,1,0, NOP, STR, 3'b000, 1, run_all);
    add(1,1,0, NOP, NOP, 3'b000, 1, pk(0,0,0,0,0,0,2'd1,0,0));
    add(0,1,0, NOP, NOP, 3'b000, 1, pk(1,1,0,0,0,0,2'd3,0,0));
    add(0,1,0, NOP, NOP, 3'b000, 1, pk(1,1,1,0,0,0,2'd3,0,0));
    add(0,1,0, NOP, NOP, 3'b000, 1, pk(1,1,1,1,0,0,2'd3,0,0));
    add(0,1,0, NOP, NOP, 3'b000, 1, run_all);
    // ADD R1 then ADD R2,R1,R1
    add(0,1,0, ADD2, ADD1, 3'b000, 1, BYP ? pk(1,1,1,1,1,0,2'd3,1,1) : pk(0,0,0,1,1,0,2'd3,0,0));
    add(0,1,0, ADD2, ADD1, 3'b000, 1, pk(1,1,1,1,1,0,2'd3,BYP,BYP));
    add(0,1,0, NOP, NOP, 3'b000, 1, run_all);
    // JMP always taken
    add(0,1,0, JMP1, NOP, 3'b000, 1, run_all);
    add(0,1,0, NOP, JMP1, 3'b000, 1, pk(0,0,0,1,1,0,2'd3,0,0));
    add(0,1,0, NOP, JMP1, 3'b000, 1, pk(0,0,0,1,1,0,2'd3,0,0));
    add(0,1,0, NOP, JMP1, 3'b000, 1, pk(1,1,0,1,1,1,2'd3,0,0));
    add(0,1,0, NOP, NOP, 3'b000, 1, run_all);
    // BR with nzp=000 never taken
    add(0,1,0, BR0, NOP, 3'b111, 1, run_all);
    add(0,1,0, NOP, BR0, 3'b111, 1, pk(0,0,0,1,1,0,2'd3,0,0));
    add(0,1,0, NOP, BR0, 3'b111, 1, pk(0,0,0,1,1,0,2'd3,0,0));
    add(0,1,0, NOP, BR0, 3'b111, 1, pk(1,1,0,1,1,0,2'd3,0,0));
    add(0,1,0, NOP, NOP, 3'b111, 1, run_all);

    @(posedge clock); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; complete_instr = tbl[i].ci; complete_data = tbl[i].cd;
      IR = tbl[i].ir; IR_Exec = tbl[i].ire; NZP = tbl[i].nzp;
      @(negedge clock);
      if (tbl[i].chk) compare($sformatf("vec%0d", i), tbl[i].exp);
      $display("vec %0d rst=%b ci=%b cd=%b IR=%h IR_Exec=%h NZP=%b out=%b", i, tbl[i].rst,
               tbl[i].ci, tbl[i].cd, tbl[i].ir, tbl[i].ire, tbl[i].nzp, actual);
      @(posedge clock); #1;
    end

    // random phase
    reset = 1'b1;
    @(posedge clock); #1;
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] op_d, op_x;
      logic prod, h1, h2, req, wt, stall, f, d, e, w, br, b1, b2;
      logic [1:0] mem;
      reset = ($urandom_range(0, 99) == 0);
      complete_instr = ($urandom_range(0, 4) != 0);
      complete_data = ($urandom_range(0, 2) == 0);
      IR = 16'($urandom); IR_Exec = 16'($urandom); NZP = 3'($urandom);
      op_d = IR[15:12]; op_x = IR_Exec[15:12];
      prod = op_x inside {4'd1, 4'd5, 4'd9};
      h1 = prod && (IR_Exec[11:9] == IR[8:6]) && (op_d inside {4'd1, 4'd5, 4'd9, 4'd6, 4'd7, 4'd12});
      h2 = prod && (op_d inside {4'd1, 4'd5}) && !IR[5] && (IR_Exec[11:9] == IR[2:0]);
      b1 = BYP && h1; b2 = BYP && h2;
      stall = 0; wt = 0; f = 0; d = 0; e = 0; w = 0; br = 0; mem = 2'd3;
      if (m_mem != 0) begin
        mem = (m_mem == 2) ? 2'd2 : {1'b0, m_store};
      end else if (m_shadow >= 0) begin
        req = (m_shadow == 0); wt = req && !complete_instr;
        f = req && !wt; e = (m_valid >= 2) && !wt; w = (m_valid >= 3) && !wt;
        br = (m_shadow == 0) && (op_x == 4'd12 || (op_x == 4'd0 && (IR_Exec[11:9] & NZP) != 0));
      end else begin
        stall = !BYP && (h1 || h2) && !m_stalled;
        req = !stall; wt = req && !complete_instr;
        f = req && !wt; d = (m_valid >= 1) && !wt && !stall;
        e = (m_valid >= 2) && !wt; w = (m_valid >= 3) && !wt;
      end
      @(negedge clock);
      compare($sformatf("rnd%0d", n), pk(f, f, d, e, w, br, mem, b1, b2));
      $display("rnd %0d rst=%b ci=%b cd=%b IR=%h IR_Exec=%h NZP=%b out=%b", n, reset,
               complete_instr, complete_data, IR, IR_Exec, NZP, actual);
      if (reset) model_reset();
      else begin
        m_stalled = stall;
        if (m_mem != 0) begin
          if (complete_data) m_mem = (m_mem == 2) ? 1 : 0;
        end else if (m_shadow >= 0) begin
          if (!wt) begin
            m_valid = (m_valid < 3) ? m_valid + 1 : 3;
            m_shadow = m_shadow - 1;
          end
        end else if (!wt) begin
          m_valid = (m_valid < 3) ? m_valid + 1 : 3;
          if (op_x == 4'd10 || op_x == 4'd11) begin
            m_mem = 2; m_store = (op_x == 4'd11);
          end else if (op_x inside {4'd2, 4'd3, 4'd6, 4'd7}) begin
            m_mem = 1; m_store = (op_x == 4'd3 || op_x == 4'd7);
          end else if (d && (op_d == 4'd0 || op_d == 4'd12)) begin
            m_shadow = BUB;
          end
        end
      end
      @(posedge clock); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
